// File: rtl/e1b_chip_seq_if.sv
// Bundle of E1B chip-sequencer signals: NCO strobes, host load port, code outputs and snapshot.
// master drives the strobes and host requests; slave is the chip sequencer.
interface e1b_chip_seq_if #(
    parameter int unsigned V_GPS_CHANS  = 12,
    parameter int unsigned E1B_CODEBITS = 12,
    parameter int unsigned CH_BITS      = 4
);
    logic [V_GPS_CHANS-1:0]              full_chip;
    logic                                ld_stb;
    logic [CH_BITS-1:0]                  ld_ch;
    logic [E1B_CODEBITS-1:0]             ld_chip;
    logic                                ld_en;
    logic                                ld_err;
    logic [V_GPS_CHANS*E1B_CODEBITS-1:0] nchip_n;
    logic [V_GPS_CHANS-1:0]              epoch;
    logic                                snap_stb;
    logic [CH_BITS-1:0]                  snap_ch;
    logic [E1B_CODEBITS-1:0]             snap_o;
    logic                                snap_valid;

    modport master (
        output full_chip, ld_stb, ld_ch, ld_chip, ld_en, snap_stb, snap_ch,
        input  ld_err, nchip_n, epoch, snap_o, snap_valid
    );

    modport slave (
        input  full_chip, ld_stb, ld_ch, ld_chip, ld_en, snap_stb, snap_ch,
        output ld_err, nchip_n, epoch, snap_o, snap_valid
    );
endinterface

// File: rtl/e1b_chip_seq.sv
// Per-channel E1B primary-code chip counters with host load/slew port, code-epoch strobes
// and an atomic snapshot bank for readback.
module e1b_chip_seq #(
    parameter int unsigned V_GPS_CHANS  = 12,
    parameter int unsigned E1B_CODEBITS = 12,
    parameter int unsigned E1B_CODELEN  = 4092,
    parameter int unsigned CH_BITS      = 4
) (
    input logic            clk,
    input logic            rst,
    e1b_chip_seq_if.slave  bus
);
    localparam logic [E1B_CODEBITS-1:0] CODE_LAST = E1B_CODEBITS'(E1B_CODELEN - 1);

    logic [V_GPS_CHANS-1:0][E1B_CODEBITS-1:0] nchip;
    logic [V_GPS_CHANS-1:0][E1B_CODEBITS-1:0] snap;
    logic [V_GPS_CHANS-1:0]                   en;
    logic [V_GPS_CHANS-1:0]                   epoch;
    logic [E1B_CODEBITS-1:0]                  snap_o;
    logic                                     snap_valid;
    logic                                     ld_err;

    logic                    ld_ch_ok;
    logic                    ld_chip_ok;
    logic                    snap_ch_ok;
    logic [V_GPS_CHANS-1:0]  ld_sel;
    logic [E1B_CODEBITS-1:0] ld_val;

    always_comb begin
        ld_ch_ok   = 32'(bus.ld_ch) < V_GPS_CHANS;
        ld_chip_ok = 32'(bus.ld_chip) < E1B_CODELEN;
        snap_ch_ok = 32'(bus.snap_ch) < V_GPS_CHANS;
        ld_val     = ld_chip_ok ? bus.ld_chip : '0;
        ld_sel     = '0;
        if (bus.ld_stb && ld_ch_ok) begin
            ld_sel[bus.ld_ch] = 1'b1;
        end
    end

    // Snapshot reads the pre-update nchip, so capture is atomic w.r.t. same-cycle advances/loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            nchip      <= '0;
            en         <= '0;
            snap       <= '0;
            epoch      <= '0;
            ld_err     <= 1'b0;
            snap_o     <= '0;
            snap_valid <= 1'b0;
        end else begin
            ld_err <= bus.ld_stb && (!ld_ch_ok || !ld_chip_ok);
            for (int c = 0; c < V_GPS_CHANS; c++) begin
                epoch[c] <= 1'b0;
                if (ld_sel[c]) begin
                    nchip[c] <= ld_val;
                    en[c]    <= bus.ld_en;
                end else if (en[c] && bus.full_chip[c]) begin
                    if (nchip[c] == CODE_LAST) begin
                        nchip[c] <= '0;
                        epoch[c] <= 1'b1;
                    end else begin
                        nchip[c] <= nchip[c] + E1B_CODEBITS'(1);
                    end
                end
            end
            if (bus.snap_stb) begin
                snap       <= nchip;
                snap_valid <= 1'b1;
            end
            snap_o <= snap_ch_ok ? snap[bus.snap_ch] : '0;
        end
    end

    // nchip_n must come straight from flops: the code memory builds its read-ahead address from it.
    assign bus.nchip_n    = nchip;
    assign bus.epoch      = epoch;
    assign bus.ld_err     = ld_err;
    assign bus.snap_o     = snap_o;
    assign bus.snap_valid = snap_valid;
endmodule

// File: tb/tb_e1b_chip_seq.sv
// Directed self-checking bench for e1b_chip_seq: loads, wraps, epochs, load errors,
// snapshot capture/readback and mid-run reset.
module tb_e1b_chip_seq;
    localparam int unsigned NCH = 12;
    localparam int unsigned CB  = 12;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [NCH*CB-1:0] saved;
    int   exp_chip [NCH];

    e1b_chip_seq_if #(.V_GPS_CHANS(NCH), .E1B_CODEBITS(CB), .CH_BITS(4)) bus ();

    e1b_chip_seq #(
        .V_GPS_CHANS (NCH),
        .E1B_CODEBITS(CB),
        .E1B_CODELEN (4092),
        .CH_BITS     (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] chip(input int c);
        return 32'(bus.nchip_n[c*CB +: CB]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.full_chip = '0;
        bus.ld_stb    = 1'b0;
        bus.ld_ch     = '0;
        bus.ld_chip   = '0;
        bus.ld_en     = 1'b0;
        bus.snap_stb  = 1'b0;
    endtask

    task automatic load(input int ch, input int val, input logic en);
        bus.ld_stb  = 1'b1;
        bus.ld_ch   = 4'(ch);
        bus.ld_chip = 12'(val);
        bus.ld_en   = en;
        tick();
        bus.ld_stb  = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle();
        bus.snap_ch = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_nchip", 32'(bus.nchip_n == '0), 1);
        check("rst_epoch", 32'(bus.epoch), 0);
        check("rst_ld_err", 32'(bus.ld_err), 0);
        check("rst_snap_valid", 32'(bus.snap_valid), 0);
        check("rst_snap_o", 32'(bus.snap_o), 0);

        // 1: disabled channel ignores full_chip
        bus.full_chip = 12'h008;
        tick();
        bus.full_chip = '0;
        check("dis_ch3", chip(3), 0);
        check("dis_epoch", 32'(bus.epoch), 0);

        // 2: wrap at 4091 -> 0 with a single epoch
        load(5, 4090, 1'b1);
        check("ld5_val", chip(5), 4090);
        check("ld5_err", 32'(bus.ld_err), 0);
        bus.full_chip = 12'h020;
        tick();
        check("adv5_4091", chip(5), 4091);
        check("adv5_no_epoch", 32'(bus.epoch), 0);
        tick();
        bus.full_chip = '0;
        check("wrap5_zero", chip(5), 0);
        check("wrap5_epoch", 32'(bus.epoch), 32'h020);
        tick();
        check("wrap5_epoch_clr", 32'(bus.epoch), 0);
        check("wrap5_other", chip(3), 0);

        // 3: out-of-range chip loads 0 and enables; out-of-range channel writes nothing
        load(2, 4095, 1'b1);
        check("bad_chip_err", 32'(bus.ld_err), 1);
        check("bad_chip_val", chip(2), 0);
        bus.full_chip = 12'h004;
        tick();
        bus.full_chip = '0;
        check("bad_chip_err_clr", 32'(bus.ld_err), 0);
        check("bad_chip_en", chip(2), 1);
        saved = bus.nchip_n;
        load(13, 7, 1'b1);
        check("bad_ch_err", 32'(bus.ld_err), 1);
        check("bad_ch_nowrite", 32'(bus.nchip_n == saved), 1);

        // 4: load beats same-cycle advance; load of 0 never raises epoch
        bus.full_chip = 12'h080;
        load(7, 100, 1'b1);
        bus.full_chip = '0;
        check("ld_wins", chip(7), 100);
        load(7, 0, 1'b1);
        check("ld0_val", chip(7), 0);
        check("ld0_no_epoch", 32'(bus.epoch), 0);
        load(7, 10, 1'b1);
        load(8, 20, 1'b1);
        check("b2b_ch7", chip(7), 10);
        check("b2b_ch8", chip(8), 20);

        // 5: staggered run then atomic snapshot with simultaneous full_chip[0]
        for (int c = 0; c < NCH; c++) begin
            load(c, c * 100 + 1, 1'b1);
        end
        bus.full_chip = 12'hAAA;
        tick();
        bus.full_chip = 12'hFFF;
        tick();
        for (int c = 0; c < NCH; c++) begin
            exp_chip[c] = c * 100 + 2 + (c % 2);
        end
        bus.full_chip = 12'h001;
        bus.snap_stb  = 1'b1;
        tick();
        idle();
        check("snap_ch0_live", chip(0), 3);
        check("snap_valid", 32'(bus.snap_valid), 1);
        for (int c = 0; c < NCH; c++) begin
            bus.snap_ch = 4'(c);
            tick();
            check($sformatf("snap_rd%0d", c), 32'(bus.snap_o), 32'(exp_chip[c]));
        end
        bus.snap_ch = 4'd3;
        #1;
        check("snap_latency", 32'(bus.snap_o), 32'(exp_chip[11]));
        tick();
        check("snap_rd3_again", 32'(bus.snap_o), 32'(exp_chip[3]));
        bus.snap_ch = 4'd12;
        tick();
        check("snap_oor", 32'(bus.snap_o), 0);

        // 6: reset overrides a running bank, a pending load and a snapshot
        bus.full_chip = 12'hFFF;
        bus.ld_stb    = 1'b1;
        bus.ld_ch     = 4'd4;
        bus.ld_chip   = 12'd55;
        bus.ld_en     = 1'b1;
        bus.snap_stb  = 1'b1;
        rst           = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        check("mid_rst_nchip", 32'(bus.nchip_n == '0), 1);
        check("mid_rst_snap_valid", 32'(bus.snap_valid), 0);
        check("mid_rst_ld_err", 32'(bus.ld_err), 0);
        bus.full_chip = 12'hFFF;
        tick();
        bus.full_chip = '0;
        check("mid_rst_en_clr", 32'(bus.nchip_n == '0), 1);
        check("mid_rst_epoch", 32'(bus.epoch), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
